reg_write_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one WIDTH-bit D-flip-flop register among NREQ requesters.
- Drives the register's data (D), store strobe (st) and clear (clr) inputs.
- Reads back the register's Q to confirm each write, then acknowledges the winning requester.
- Sits between the requester logic and the shared flip-flop register at the next level up.

---
 rtl/reg_arb_pkg.sv | 16 +
 rtl/reg_write_arbiter_rr_pick.sv | 29 ++
 rtl/reg_write_arbiter.sv | 94 +++++++++
 tb/tb_reg_write_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for the round-robin register write arbiter.
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        STORE,
        VERIFY
    } arb_state_t;

    // Index width for n requesters; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
    import reg_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            valid,
    output logic [IDW-1:0]  id
);

    logic [NREQ-1:0] rot;

    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        valid = |req;
        id    = '0;
        // Rotating the doubled vector puts the request at ptr in bit 0.
        rot   = NREQ'({req, req} >> ptr);
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                id = IDW'((int'(ptr) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin sequencer sharing one D flip-flop register among NREQ writers.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        clr,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ*WIDTH-1:0]       wdata,
    input  logic                        clr_req,
    input  logic [WIDTH-1:0]            reg_q,
    output logic [WIDTH-1:0]            reg_d,
    output logic                        reg_st,
    output logic                        reg_clr,
    output logic [NREQ-1:0]             ack,
    output logic                        wr_err,
    output logic [id_width(NREQ)-1:0]   grant_id,
    output logic                        busy
);

    localparam int IDW = id_width(NREQ);

    arb_state_t       state;
    arb_state_t       state_next;
    logic [IDW-1:0]   rr_ptr;
    logic [WIDTH-1:0] data_l;
    logic             pick_valid;
    logic [IDW-1:0]   pick_id;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .id    (pick_id)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_next = CLEAR;
                end else if (pick_valid) begin
                    state_next = STORE;
                end
            end
            CLEAR:   state_next = IDLE;
            STORE:   state_next = VERIFY;
            VERIFY:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            data_l   <= '0;
            reg_st   <= 1'b0;
            ack      <= '0;
        end else begin
            state  <= state_next;
            reg_st <= 1'b0;
            ack    <= '0;
            case (state)
                IDLE: begin
                    if (!clr_req && pick_valid) begin
                        grant_id <= pick_id;
                        data_l   <= wdata[pick_id*WIDTH +: WIDTH];
                        reg_st   <= 1'b1;
                    end
                end
                CLEAR:  data_l <= '0;
                STORE:  ack[grant_id] <= 1'b1;
                VERIFY: rr_ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
                default: ;
            endcase
        end
    end

    assign reg_d   = data_l;
    assign reg_clr = clr | (state == CLEAR);
    assign busy    = (state != IDLE);
    // Readback only exists after the STORE edge, so the compare is taken live during VERIFY.
    assign wr_err  = (|ack) & (reg_q != data_l);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench: vector table plus corner sequences, with an ack scoreboard.
module tb_reg_write_arbiter;

    typedef struct packed {
        logic [3:0]  req;
        logic [15:0] wdata;
        logic        force0;
        logic        drop;
        logic [1:0]  id;
        logic [3:0]  d;
        logic [3:0]  q;
        logic        err;
    } vec_t;

    typedef struct packed {
        logic [3:0] ack;
        logic       err;
        logic [1:0] id;
        logic [3:0] q;
    } exp_t;

    localparam int NVEC = 11;

    logic        clk;
    logic        clr;
    logic        clr_req;
    logic        force_zero;
    logic [3:0]  req;
    logic [15:0] wdata;
    logic [3:0]  reg_q;
    logic [3:0]  reg_d;
    logic [3:0]  q_model;
    logic [3:0]  ack;
    logic        reg_st;
    logic        reg_clr;
    logic        wr_err;
    logic        busy;
    logic [1:0]  grant_id;

    int   cyc;
    int   errors;
    int   checks;
    int   clr_cyc;
    vec_t vecs [NVEC];
    exp_t sb [$];
    int   ack_cyc [$];

    reg_write_arbiter #(
        .NREQ  (4),
        .WIDTH (4)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .req      (req),
        .wdata    (wdata),
        .clr_req  (clr_req),
        .reg_q    (reg_q),
        .reg_d    (reg_d),
        .reg_st   (reg_st),
        .reg_clr  (reg_clr),
        .ack      (ack),
        .wr_err   (wr_err),
        .grant_id (grant_id),
        .busy     (busy)
    );

    // Shared 4-bit flip-flop register; its load input is tied to st.
    always @(posedge clk) begin
        if (reg_clr) q_model <= 4'h0;
        else if (reg_st) q_model <= reg_d;
    end
    assign reg_q = force_zero ? 4'h0 : q_model;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int n = 0; n < budget && sb.size() != 0; n++) @(posedge clk);
        check(name, 32'(sb.size()), 32'd0);
        if (sb.size() != 0) sb.delete();
    endtask

    task automatic push_exp(input logic [1:0] id, input logic [3:0] q, input logic err);
        exp_t e;
        e.ack = 4'b0001 << id;
        e.err = err;
        e.id  = id;
        e.q   = q;
        sb.push_back(e);
    endtask

    // Scoreboard: every ack pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (ack != 4'b0000) begin
            ack_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'(ack), 32'd0);
            end else begin
                e = sb.pop_front();
                check("ack", 32'(ack), 32'(e.ack));
                check("wr_err", 32'(wr_err), 32'(e.err));
                check("grant_id", 32'(grant_id), 32'(e.id));
                check("reg_q", 32'(reg_q), 32'(e.q));
            end
        end else if (cyc > 0 && wr_err !== 1'b0) begin
            check("wr_err_without_ack", 32'(wr_err), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        errors     = 0;
        checks     = 0;
        clr        = 1'b1;
        clr_req    = 1'b0;
        force_zero = 1'b0;
        req        = 4'b0000;
        wdata      = 16'h0000;

        //            req      wdata     f0    drop  id     d     q     err
        vecs[0]  = '{4'b0001, 16'h000A, 1'b0, 1'b0, 2'd0, 4'hA, 4'hA, 1'b0};
        vecs[1]  = '{4'b0001, 16'h0003, 1'b0, 1'b1, 2'd0, 4'h3, 4'h3, 1'b0};
        vecs[2]  = '{4'b1001, 16'h7001, 1'b0, 1'b0, 2'd3, 4'h7, 4'h7, 1'b0};
        vecs[3]  = '{4'b1001, 16'h7006, 1'b0, 1'b0, 2'd0, 4'h6, 4'h6, 1'b0};
        vecs[4]  = '{4'b0110, 16'h0920, 1'b0, 1'b0, 2'd1, 4'h2, 4'h2, 1'b0};
        vecs[5]  = '{4'b0011, 16'h0054, 1'b0, 1'b0, 2'd0, 4'h4, 4'h4, 1'b0};
        vecs[6]  = '{4'b0100, 16'h0F00, 1'b1, 1'b0, 2'd2, 4'hF, 4'h0, 1'b1};
        vecs[7]  = '{4'b1100, 16'hC800, 1'b0, 1'b0, 2'd3, 4'hC, 4'hC, 1'b0};
        vecs[8]  = '{4'b1111, 16'hEDCB, 1'b0, 1'b0, 2'd0, 4'hB, 4'hB, 1'b0};
        vecs[9]  = '{4'b1010, 16'h5060, 1'b0, 1'b0, 2'd1, 4'h6, 4'h6, 1'b0};
        vecs[10] = '{4'b1001, 16'h9008, 1'b0, 1'b0, 2'd3, 4'h9, 4'h9, 1'b0};

        // Reset: two cycles of clr.
        repeat (2) begin
            @(negedge clk);
            check("rst_reg_clr", 32'(reg_clr), 32'd1);
            check("rst_busy", 32'(busy), 32'd0);
        end
        @(posedge clk); #1;
        clr = 1'b0;
        @(negedge clk);
        check("post_rst_reg_clr", 32'(reg_clr), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_ack", 32'(ack), 32'd0);
        check("post_rst_reg_st", 32'(reg_st), 32'd0);
        check("post_rst_reg_d", 32'(reg_d), 32'd0);
        check("post_rst_grant_id", 32'(grant_id), 32'd0);
        check("post_rst_wr_err", 32'(wr_err), 32'd0);
        check("post_rst_q", 32'(q_model), 32'd0);

        // Table-driven single writes through the rotating pointer.
        for (int i = 0; i < NVEC; i++) begin
            @(posedge clk); #1;
            req        = vecs[i].req;
            wdata      = vecs[i].wdata;
            force_zero = vecs[i].force0;
            push_exp(vecs[i].id, vecs[i].q, vecs[i].err);
            @(negedge clk);
            check("c0_busy", 32'(busy), 32'd0);
            check("c0_reg_st", 32'(reg_st), 32'd0);
            @(posedge clk); #1;
            wdata = ~vecs[i].wdata;
            if (vecs[i].drop) req = 4'b0000;
            @(negedge clk);
            check("c1_reg_st", 32'(reg_st), 32'd1);
            check("c1_reg_d", 32'(reg_d), 32'(vecs[i].d));
            check("c1_busy", 32'(busy), 32'd1);
            @(negedge clk);
            @(posedge clk); #1;
            req        = 4'b0000;
            force_zero = 1'b0;
            check("vec_drain", 32'(sb.size()), 32'd0);
            if (sb.size() != 0) sb.delete();
        end

        // Clear request beats a simultaneous write request.
        ack_cyc.delete();
        @(posedge clk); #1;
        clr_req = 1'b1;
        req     = 4'b0100;
        wdata   = 16'h0500;
        push_exp(2'd2, 4'h5, 1'b0);
        @(negedge clk);
        check("clrq_c0_busy", 32'(busy), 32'd0);
        check("clrq_c0_reg_clr", 32'(reg_clr), 32'd0);
        @(posedge clk); #1;
        clr_req = 1'b0;
        @(negedge clk);
        clr_cyc = cyc;
        check("clrq_reg_clr", 32'(reg_clr), 32'd1);
        check("clrq_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("clrq_q_zero", 32'(q_model), 32'd0);
        check("clrq_reg_clr_off", 32'(reg_clr), 32'd0);
        check("clrq_reg_d_zero", 32'(reg_d), 32'd0);
        wait_drain("clrq_drain", 10);
        #1;
        req = 4'b0000;
        check("clrq_ack_count", 32'(ack_cyc.size()), 32'd1);
        if (ack_cyc.size() > 0) check("clrq_latency", 32'(ack_cyc[0] - clr_cyc), 32'd3);

        // Controller reset during STORE aborts the write.
        @(posedge clk); #1;
        req   = 4'b0010;
        wdata = 16'h0090;
        @(negedge clk);
        @(negedge clk);
        check("abort_reg_st", 32'(reg_st), 32'd1);
        check("abort_reg_d", 32'(reg_d), 32'd9);
        clr = 1'b1;
        #1;
        check("abort_reg_clr", 32'(reg_clr), 32'd1);
        @(posedge clk); #1;
        clr = 1'b0;
        req = 4'b0000;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ack", 32'(ack), 32'd0);
        check("abort_q", 32'(q_model), 32'd0);
        check("abort_grant_id", 32'(grant_id), 32'd0);
        check("abort_reg_d", 32'(reg_d), 32'd0);
        repeat (3) @(negedge clk);

        // Fairness: all requests held, rotation starts at 0 after reset.
        ack_cyc.delete();
        @(posedge clk); #1;
        wdata = 16'h4321;
        req   = 4'b1111;
        push_exp(2'd0, 4'h1, 1'b0);
        push_exp(2'd1, 4'h2, 1'b0);
        push_exp(2'd2, 4'h3, 1'b0);
        push_exp(2'd3, 4'h4, 1'b0);
        push_exp(2'd0, 4'h1, 1'b0);
        wait_drain("fair_drain", 30);
        #1;
        req = 4'b0000;
        check("fair_ack_count", 32'(ack_cyc.size()), 32'd5);
        if (ack_cyc.size() >= 5) begin
            for (int k = 1; k < 5; k++) begin
                check("fair_spacing", 32'(ack_cyc[k] - ack_cyc[k-1]), 32'd3);
            end
        end
        repeat (4) @(negedge clk);
        check("final_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
